// File: rtl/mult_div_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mult_div_unit_pkg                                      |
// | Description : Funct codes, bus widths and decode helpers shared by   |
// |               the multiply/divide engine and its interface.          |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package mult_div_unit_pkg;

    localparam int c_funct_w = 6;

    typedef logic [c_funct_w-1:0] funct_t;

    localparam funct_t c_funct_mult  = 6'b011000;
    localparam funct_t c_funct_multu = 6'b011001;
    localparam funct_t c_funct_div   = 6'b011010;
    localparam funct_t c_funct_divu  = 6'b011011;

    // True for any of the four codes this engine executes
    function automatic logic is_md_funct(input funct_t f);
        return (f == c_funct_mult) || (f == c_funct_multu) ||
               (f == c_funct_div)  || (f == c_funct_divu);
    endfunction

    function automatic logic is_div_funct(input funct_t f);
        return (f == c_funct_div) || (f == c_funct_divu);
    endfunction

    function automatic logic is_signed_funct(input funct_t f);
        return (f == c_funct_mult) || (f == c_funct_div);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mult_div_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mult_div_unit_if                                       |
// | Description : Request / result bundle between the EX stage (master) |
// |               and the multiply/divide engine (slave).                |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic                            start;
    mult_div_unit_pkg::funct_t       funct;
    logic [WIDTH-1:0]                operand_1;
    logic [WIDTH-1:0]                operand_2;
    logic                            cancel;
    logic                            busy;
    logic                            mult_div_done;
    logic [2*WIDTH-1:0]              mult_div_result;

    modport master (
        output start, funct, operand_1, operand_2, cancel,
        input  busy, mult_div_done, mult_div_result
    );

    modport slave (
        input  start, funct, operand_1, operand_2, cancel,
        output busy, mult_div_done, mult_div_result
    );
endinterface
`default_nettype wire

// File: rtl/mult_div_unit_div_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mult_div_unit_div_step                                 |
// | Description : One combinational restoring-divide iteration on the    |
// |               {rem, quot} pair against a fixed divisor.              |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module mult_div_unit_div_step #(
    parameter int WIDTH = 32
) (
    input  wire logic [WIDTH-1:0] rem,
    input  wire logic [WIDTH-1:0] quot,
    input  wire logic [WIDTH-1:0] divisor,
    output logic      [WIDTH-1:0] next_rem,
    output logic      [WIDTH-1:0] next_quot
);

    // Shifted remainder needs one extra bit: rem < divisor, but 2*rem+1 may not fit
    logic [WIDTH:0]   w_shift_rem;
    logic             w_fits;
    logic [WIDTH-1:0] w_diff;

    assign w_shift_rem = {rem, quot[WIDTH-1]};
    assign w_fits      = (w_shift_rem >= {1'b0, divisor});
    // When the subtraction is taken the difference is below divisor, so it fits WIDTH bits
    assign w_diff      = w_shift_rem[WIDTH-1:0] - divisor;

    // Keep the trial difference only when it did not go negative
    always_comb begin
        next_rem  = w_shift_rem[WIDTH-1:0];
        next_quot = {quot[WIDTH-2:0], 1'b0};
        if (w_fits) begin
            next_rem  = w_diff;
            next_quot = {quot[WIDTH-2:0], 1'b1};
        end
    end

endmodule
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mult_div_unit                                          |
// | Description : Iterative radix-2 multiply / restoring divide engine,  |
// |               one bit per cycle, 64-bit {hi,lo} result with a        |
// |               single-cycle done pulse.                               |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input wire logic        clk,
    input wire logic        rst,
    mult_div_unit_if.slave  md
);

    localparam int c_cnt_w = $clog2(WIDTH);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_mul  = 2'd1;
    localparam logic [1:0] c_st_div  = 2'd2;
    localparam logic [1:0] c_st_done = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [c_cnt_w-1:0] r_cnt;
    // MUL: {partial product hi, multiplier / product lo}; DIV: {remainder, quotient}
    logic [2*WIDTH-1:0] r_acc;
    // Multiplicand for MUL, divisor for DIV (magnitudes for signed ops)
    logic [WIDTH-1:0]   r_opnd;
    logic               r_is_div;
    logic               r_neg_res;
    logic               r_neg_rem;
    logic [2*WIDTH-1:0] r_result;

    logic               w_accept;
    logic               w_is_div;
    logic               w_op1_neg;
    logic               w_op2_neg;
    logic               w_div_zero;
    logic [WIDTH-1:0]   w_op1_abs;
    logic [WIDTH-1:0]   w_op2_abs;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH-1:0]   w_div_rem;
    logic [WIDTH-1:0]   w_div_quot;
    logic [2*WIDTH-1:0] w_fixed;

    assign w_accept   = (r_state == c_st_idle) && md.start && !md.cancel && is_md_funct(md.funct);
    assign w_is_div   = is_div_funct(md.funct);
    assign w_op1_neg  = is_signed_funct(md.funct) && md.operand_1[WIDTH-1];
    assign w_op2_neg  = is_signed_funct(md.funct) && md.operand_2[WIDTH-1];
    assign w_op1_abs  = w_op1_neg ? -md.operand_1 : md.operand_1;
    assign w_op2_abs  = w_op2_neg ? -md.operand_2 : md.operand_2;
    assign w_div_zero = w_is_div && (md.operand_2 == '0);

    // Add multiplicand into the upper half when the multiplier LSB is set, then shift right
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    mult_div_unit_div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .rem       (r_acc[2*WIDTH-1:WIDTH]),
        .quot      (r_acc[WIDTH-1:0]),
        .divisor   (r_opnd),
        .next_rem  (w_div_rem),
        .next_quot (w_div_quot)
    );

    // Restore signs on the magnitude result; divide-by-zero has both flags clear
    always_comb begin
        w_fixed = r_acc;
        if (r_is_div) begin
            w_fixed[WIDTH-1:0]       = r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
            w_fixed[2*WIDTH-1:WIDTH] = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
        end else if (r_neg_res) begin
            w_fixed = -r_acc;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: cancel beats everything, divide-by-zero skips straight to DONE
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_accept) begin
                    if (w_div_zero)    w_next_state = c_st_done;
                    else if (w_is_div) w_next_state = c_st_div;
                    else               w_next_state = c_st_mul;
                end
            end
            c_st_mul, c_st_div: begin
                if (md.cancel)           w_next_state = c_st_idle;
                else if (r_cnt == '0)    w_next_state = c_st_done;
            end
            c_st_done: w_next_state = c_st_idle;
            default:   w_next_state = c_st_idle;
        endcase
    end

    // Outputs: the result is presented in the done cycle itself, then held in r_result
    always_comb begin
        md.busy            = (r_state != c_st_idle);
        md.mult_div_done   = (r_state == c_st_done) && !md.cancel;
        md.mult_div_result = md.mult_div_done ? w_fixed : r_result;
    end

    // Operand capture, per-cycle iteration and result commit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_acc     <= '0;
            r_opnd    <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_result  <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        r_cnt    <= c_cnt_w'(WIDTH - 1);
                        r_is_div <= w_is_div;
                        if (w_div_zero) begin
                            r_acc     <= {md.operand_1, {WIDTH{1'b1}}};
                            r_opnd    <= md.operand_2;
                            r_neg_res <= 1'b0;
                            r_neg_rem <= 1'b0;
                        end else if (w_is_div) begin
                            r_acc     <= {{WIDTH{1'b0}}, w_op1_abs};
                            r_opnd    <= w_op2_abs;
                            r_neg_res <= w_op1_neg ^ w_op2_neg;
                            r_neg_rem <= w_op1_neg;
                        end else begin
                            r_acc     <= {{WIDTH{1'b0}}, w_op2_abs};
                            r_opnd    <= w_op1_abs;
                            r_neg_res <= w_op1_neg ^ w_op2_neg;
                            r_neg_rem <= 1'b0;
                        end
                    end
                end
                c_st_mul: begin
                    r_acc <= w_mul_next;
                    r_cnt <= r_cnt - 1'b1;
                end
                c_st_div: begin
                    r_acc <= {w_div_rem, w_div_quot};
                    r_cnt <= r_cnt - 1'b1;
                end
                c_st_done: begin
                    if (!md.cancel) r_result <= w_fixed;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_mult_div_unit                                       |
// | Description : Self-checking bench for mult_div_unit: directed corner |
// |               cases plus random ops against a 64-bit arithmetic      |
// |               reference model.                                       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [63:0] last_res = '0;

    mult_div_unit_if #(.WIDTH(32)) md ();

    mult_div_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .md  (md)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic; SV division truncates toward zero, % follows dividend sign
    function automatic logic [63:0] ref_model(input funct_t f, input logic [31:0] a, input logic [31:0] b);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint unsigned ua = {32'd0, a};
        longint unsigned ub = {32'd0, b};
        longint          sq;
        longint          sr;
        longint unsigned uq;
        longint unsigned ur;
        logic [63:0]     res = '0;
        case (f)
            c_funct_mult:  res = sa * sb;
            c_funct_multu: res = ua * ub;
            c_funct_div: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else begin
                    sq = sa / sb;
                    sr = sa % sb;
                    res = {sr[31:0], sq[31:0]};
                end
            end
            c_funct_divu: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else begin
                    uq = ua / ub;
                    ur = ua % ub;
                    res = {ur[31:0], uq[31:0]};
                end
            end
            default: res = '0;
        endcase
        return res;
    endfunction

    function automatic int exp_latency(input funct_t f, input logic [31:0] b);
        return ((f == c_funct_div || f == c_funct_divu) && b == 32'd0) ? 1 : 33;
    endfunction

    // Called at a falling edge; returns at the falling edge of cycle 1
    task automatic launch(input funct_t f, input logic [31:0] a, input logic [31:0] b);
        md.start     = 1'b1;
        md.funct     = f;
        md.operand_1 = a;
        md.operand_2 = b;
        @(negedge clk);
        md.start     = 1'b0;
    endtask

    // Observe cycles 1..40: busy window, exactly one done at the expected cycle, result and hold
    task automatic watch(input string tag, input int lat, input logic [63:0] exp);
        int          ndone   = 0;
        int          dcyc    = 0;
        logic        busy_ok = 1'b1;
        logic [63:0] got     = '0;
        for (int c = 1; c <= 40; c++) begin
            if (md.busy !== (c <= lat)) busy_ok = 1'b0;
            if (md.mult_div_done === 1'b1) begin
                ndone++;
                dcyc = c;
                got  = md.mult_div_result;
            end
            @(negedge clk);
        end
        check({tag, "_done_count"}, 64'(ndone), 64'd1);
        check({tag, "_done_cycle"}, 64'(dcyc), 64'(lat));
        check({tag, "_result"}, got, exp);
        check({tag, "_hold"}, md.mult_div_result, exp);
        check({tag, "_busy_window"}, {63'd0, busy_ok}, 64'd1);
        last_res = exp;
    endtask

    task automatic run_op(input string tag, input funct_t f, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp);
        launch(f, a, b);
        watch(tag, exp_latency(f, b), exp);
    endtask

    // Count done pulses over n cycles with no new request
    task automatic count_done(input int n, output int ndone);
        ndone = 0;
        for (int c = 0; c < n; c++) begin
            if (md.mult_div_done === 1'b1) ndone++;
            @(negedge clk);
        end
    endtask

    function automatic logic [31:0] rand_operand();
        int sel = $urandom_range(0, 7);
        case (sel)
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int          nd;
        int          ndone;
        funct_t      f;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] got;

        md.start = 1'b0; md.funct = '0; md.operand_1 = '0; md.operand_2 = '0; md.cancel = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy",   {63'd0, md.busy}, 64'd0);
        check("rst_done",   {63'd0, md.mult_div_done}, 64'd0);
        check("rst_result", md.mult_div_result, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Unknown funct is ignored
        launch(6'h20, 32'd5, 32'd7);
        check("bad_funct_busy", {63'd0, md.busy}, 64'd0);
        @(negedge clk);

        // Directed corner cases
        run_op("multu_max", c_funct_multu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        run_op("mult_neg",  c_funct_mult,  32'hFFFF_FFFD, 32'd5,        64'hFFFF_FFFF_FFFF_FFF1);
        run_op("div_neg",   c_funct_div,   32'hFFFF_FFF9, 32'd2,        64'hFFFF_FFFF_FFFF_FFFD);
        run_op("div_ovf",   c_funct_div,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
        run_op("divu_7",    c_funct_divu,  32'd100,       32'd7,        64'h0000_0002_0000_000E);
        run_op("divu_zero", c_funct_divu,  32'd100,       32'd0,        64'h0000_0064_FFFF_FFFF);

        // Cancel mid-multiply at cycle 10
        launch(c_funct_multu, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (9) @(negedge clk);
        md.cancel = 1'b1;
        @(negedge clk);
        md.cancel = 1'b0;
        check("cancel_busy", {63'd0, md.busy}, 64'd0);
        count_done(40, ndone);
        check("cancel_no_done", 64'(ndone), 64'd0);
        check("cancel_result", md.mult_div_result, last_res);

        // Start together with cancel in IDLE
        md.cancel = 1'b1;
        launch(c_funct_mult, 32'd3, 32'd4);
        md.cancel = 1'b0;
        check("start_cancel_busy", {63'd0, md.busy}, 64'd0);
        count_done(40, ndone);
        check("start_cancel_no_done", 64'(ndone), 64'd0);

        // Cancel during the DONE cycle of a divide-by-zero
        launch(c_funct_divu, 32'd77, 32'd0);
        md.cancel = 1'b1;
        #1;
        check("cancel_done_pulse", {63'd0, md.mult_div_done}, 64'd0);
        @(negedge clk);
        md.cancel = 1'b0;
        check("cancel_done_busy", {63'd0, md.busy}, 64'd0);
        check("cancel_done_result", md.mult_div_result, last_res);

        // A start while busy is ignored
        launch(c_funct_multu, 32'd1234, 32'd5678);
        nd = 0;
        got = '0;
        for (int c = 1; c <= 40; c++) begin
            md.start     = (c == 5);
            md.funct     = c_funct_divu;
            md.operand_1 = 32'd9;
            md.operand_2 = 32'd0;
            if (md.mult_div_done === 1'b1) begin
                nd++;
                got = md.mult_div_result;
            end
            @(negedge clk);
        end
        md.start = 1'b0;
        check("busy_start_done_count", 64'(nd), 64'd1);
        check("busy_start_result", got, 64'd7006652);
        last_res = 64'd7006652;

        // Asynchronous reset at cycle 15 of a DIVU
        launch(c_funct_divu, 32'hDEAD_BEEF, 32'd3);
        repeat (14) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_busy",   {63'd0, md.busy}, 64'd0);
        check("async_rst_done",   {63'd0, md.mult_div_done}, 64'd0);
        check("async_rst_result", md.mult_div_result, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        count_done(40, ndone);
        check("async_rst_no_done", 64'(ndone), 64'd0);

        // Random ops against the reference model
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0:       f = c_funct_mult;
                1:       f = c_funct_multu;
                2:       f = c_funct_div;
                default: f = c_funct_divu;
            endcase
            a = rand_operand();
            b = rand_operand();
            run_op("rand", f, a, b, ref_model(f, a, b));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
